// File: rtl/token_merge_arbiter.sv
// Two-input 4-phase merge arbiter: synchronizes the async handshakes, grants the shared
// downstream latch/stage round-robin, and counts completed transfers.

module tma_sync #(
  parameter int STAGES = 2
) (
  input  logic CP,
  input  logic RESET,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_q;

  always_ff @(posedge CP) begin
    if (RESET) r_q <= '0;
    else       r_q <= {r_q[STAGES-2:0], i_d};
  end

  assign o_q = r_q[STAGES-1];
endmodule

module token_merge_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             CP,
  input  logic             RESET,
  input  logic             SENDIN0,
  input  logic             SENDIN1,
  output logic             ACKOUT0,
  output logic             ACKOUT1,
  output logic             SENDOUT,
  input  logic             ACKIN,
  output logic             SEL,
  output logic             LOPEN,
  output logic [CNT_W-1:0] XFERCNT
);
  typedef enum logic [1:0] {IDLE, LATCH, SEND, RELEASE} state_t;

  logic [2:0] w_async, w_sync;
  logic [1:0] w_s;
  logic       w_ak;

  assign w_async = {ACKIN, SENDIN1, SENDIN0};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    tma_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .CP   (CP),
      .RESET(RESET),
      .i_d  (w_async[g]),
      .o_q  (w_sync[g])
    );
  end

  assign w_s  = w_sync[1:0];
  assign w_ak = w_sync[2];

  state_t           r_state, w_next;
  logic             r_sel, w_sel_nxt;
  logic             r_last, w_last_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_lopen, r_sendout;
  logic [1:0]       r_ack;

  always_comb begin
    w_next     = r_state;
    w_sel_nxt  = r_sel;
    w_last_nxt = r_last;
    w_cnt_nxt  = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_s[0] || w_s[1]) begin
          w_next    = LATCH;
          // on a tie the requester not served last wins
          w_sel_nxt = (w_s[0] && w_s[1]) ? ~r_last : w_s[1];
        end
      end
      LATCH:   w_next = SEND;
      SEND:    if (w_ak) w_next = RELEASE;
      RELEASE: begin
        if (!w_s[r_sel] && !w_ak) begin
          w_next     = IDLE;
          w_last_nxt = r_sel;
          w_cnt_nxt  = r_cnt + 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered copies decoded from the state being entered.
  always_ff @(posedge CP) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_sel     <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_lopen   <= 1'b0;
      r_sendout <= 1'b0;
      r_ack     <= 2'b00;
    end else begin
      r_state   <= w_next;
      r_sel     <= w_sel_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lopen   <= (w_next == LATCH);
      r_sendout <= (w_next == SEND);
      r_ack     <= (w_next == RELEASE) ? (w_sel_nxt ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  assign ACKOUT0 = r_ack[0];
  assign ACKOUT1 = r_ack[1];
  assign SENDOUT = r_sendout;
  assign SEL     = r_sel;
  assign LOPEN   = r_lopen;
  assign XFERCNT = r_cnt;
endmodule
